// File: rtl/fram_bank_arbiter.sv
// fram_bank_arbiter: shares interleaved feature banks between a priority read port and a write port
// whose bank conflicts stall into an in-order write queue with read forwarding.
module fram_bank_arbiter #(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int BANK_NUM        = 4,
    parameter int BANK_ADDR_WIDTH = ADDR_WIDTH - $clog2(BANK_NUM),
    parameter int WQ_DEPTH        = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rp_en,
    input  logic [ADDR_WIDTH-1:0]                 rp_addr,
    output logic [DATA_WIDTH-1:0]                 rp_rdata,
    output logic                                  rp_rvalid,
    input  logic                                  wp_en,
    input  logic [ADDR_WIDTH-1:0]                 wp_addr,
    input  logic [DATA_WIDTH-1:0]                 wp_wdata,
    output logic                                  wp_ready,
    output logic [BANK_NUM*BANK_ADDR_WIDTH-1:0]   bram_addr,
    output logic [BANK_NUM*DATA_WIDTH-1:0]        bram_wdata,
    output logic [BANK_NUM-1:0]                   bram_we,
    output logic [BANK_NUM-1:0]                   bram_en,
    input  logic [BANK_NUM*DATA_WIDTH-1:0]        bram_rdata,
    output logic [$clog2(WQ_DEPTH):0]             wq_count,
    output logic                                  wq_empty,
    output logic                                  wp_overflow,
    output logic [CNT_WIDTH-1:0]                  conflict_cnt
);
    localparam int BSEL = $clog2(BANK_NUM);
    localparam int QW = $clog2(WQ_DEPTH);
    localparam logic [QW:0] FULL = (QW+1)'(WQ_DEPTH);

    logic [ADDR_WIDTH-1:0] wq_addr_q [WQ_DEPTH];
    logic [DATA_WIDTH-1:0] wq_data_q [WQ_DEPTH];
    logic [QW-1:0]         head_q, tail_q;
    logic [QW:0]           count_q, count_d;
    logic                  rvalid_q, hit_q, hit_d, ovf_q;
    logic [DATA_WIDTH-1:0] fwd_q, fwd_d;
    logic [BSEL-1:0]       rbank_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  empty, accept, cand_v, issue, enq, deq;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic [DATA_WIDTH-1:0] cand_data;

    assign empty     = count_q == '0;
    assign wp_ready  = count_q != FULL;
    assign accept    = wp_en && wp_ready;
    assign cand_v    = !empty || accept;
    assign cand_addr = empty ? wp_addr : wq_addr_q[head_q];
    assign cand_data = empty ? wp_wdata : wq_data_q[head_q];
    assign issue     = cand_v && !(rp_en && rp_addr[BSEL-1:0] == cand_addr[BSEL-1:0]);
    assign deq       = !empty && issue;
    assign enq       = accept && !(empty && issue);
    assign count_d   = count_q + (QW+1)'(enq) - (QW+1)'(deq);

    // Walk oldest to youngest so the last hit is the youngest queued write.
    always_comb begin
        hit_d = 1'b0;
        fwd_d = '0;
        for (int i = 0; i < WQ_DEPTH; i++) begin
            if ((QW+1)'(i) < count_q && wq_addr_q[head_q + QW'(i)] == rp_addr) begin
                hit_d = 1'b1;
                fwd_d = wq_data_q[head_q + QW'(i)];
            end
        end
    end

    always_comb begin
        bram_addr  = '0;
        bram_wdata = '0;
        bram_en    = '0;
        bram_we    = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            bram_addr[b*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH] =
                (rp_en && rp_addr[BSEL-1:0] == BSEL'(b)) ? rp_addr[ADDR_WIDTH-1:BSEL] : cand_addr[ADDR_WIDTH-1:BSEL];
            bram_wdata[b*DATA_WIDTH +: DATA_WIDTH] = cand_data;
            bram_we[b] = rst_n && issue && cand_addr[BSEL-1:0] == BSEL'(b);
            bram_en[b] = rst_n && ((rp_en && rp_addr[BSEL-1:0] == BSEL'(b)) || (issue && cand_addr[BSEL-1:0] == BSEL'(b)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            hit_q    <= 1'b0;
            fwd_q    <= '0;
            rbank_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            count_q  <= count_d;
            rvalid_q <= rp_en;
            if (enq) begin
                wq_addr_q[tail_q] <= wp_addr;
                wq_data_q[tail_q] <= wp_wdata;
                tail_q            <= tail_q + QW'(1);
            end
            if (deq) head_q <= head_q + QW'(1);
            if (rp_en) begin
                hit_q   <= hit_d;
                fwd_q   <= fwd_d;
                rbank_q <= rp_addr[BSEL-1:0];
            end
            if (wp_en && !wp_ready) ovf_q <= 1'b1;
            if (cand_v && !issue && cnt_q != '1) cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign rp_rdata     = hit_q ? fwd_q : bram_rdata[rbank_q*DATA_WIDTH +: DATA_WIDTH];
    assign rp_rvalid    = rvalid_q;
    assign wq_count     = count_q;
    assign wq_empty     = empty;
    assign wp_overflow  = ovf_q;
    assign conflict_cnt = cnt_q;
endmodule
